// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller for the 16-bit microprocessor.
// Sequences the PC strobes and memory handshakes, and holds the fetched instruction.
module pc_sequencer #(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  input  logic            dmem_ack,
  input  logic            zero_flag,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [OPW-1:0]  dmem_addr,
  output logic            count_enable,
  output logic            load_address,
  output logic            jump_enable,
  output logic [IW-1:0]   jump_address,
  output logic            exec_valid,
  output logic [3:0]      alu_op,
  output logic [IW-1:0]   ir,
  output logic            busy,
  output logic            halted
);

  localparam logic [3:0] OpAlu  = 4'h1;
  localparam logic [3:0] OpLd   = 4'h2;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpJmp  = 4'h8;
  localparam logic [3:0] OpJz   = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [3:0]      opcode;

  assign opcode       = ir_q[IW-1:IW-4];
  assign ir           = ir_q;
  assign alu_op       = ir_q[11:8];
  assign dmem_addr    = ir_q[OPW-1:0];
  // Jump targets stay inside the low 4K window.
  assign jump_address = {{(IW-OPW){1'b0}}, ir_q[OPW-1:0]};

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    count_enable = 1'b0;
    load_address = 1'b0;
    jump_enable  = 1'b0;
    exec_valid   = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req     = 1'b1;
        load_address = 1'b1;
        busy         = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        load_address = 1'b1;
        busy         = 1'b1;
        if (opcode == OpHalt) begin
          state_d = StHalt;
        end else if (opcode == OpLd || opcode == OpSt) begin
          state_d = StMem;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        load_address = 1'b1;
        busy         = 1'b1;
        state_d      = StFetch;
        if (opcode == OpJmp) begin
          jump_enable = 1'b1;
        end else if (opcode == OpJz) begin
          jump_enable  = zero_flag;
          count_enable = ~zero_flag;
        end else begin
          // NOP, ALU and undefined opcodes all just step the PC.
          count_enable = 1'b1;
          exec_valid   = (opcode == OpAlu);
        end
      end
      StMem: begin
        dmem_req     = 1'b1;
        dmem_we      = (opcode == OpSt);
        load_address = 1'b1;
        busy         = 1'b1;
        if (dmem_ack) begin
          count_enable = 1'b1;
          exec_valid   = (opcode == OpLd);
          state_d      = StFetch;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed programs plus randomized instruction streams,
// compared cycle by cycle against expectations derived from the instruction semantics.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_ack;
  logic        zero_flag;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic        count_enable;
  logic        load_address;
  logic        jump_enable;
  logic [15:0] jump_address;
  logic        exec_valid;
  logic [3:0]  alu_op;
  logic [15:0] ir;
  logic        busy;
  logic        halted;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] tb_pc;
  logic [15:0] exp_pc;
  logic [15:0] cur_ir;
  logic [8:0]  ctrl;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .dmem_ack     (dmem_ack),
    .zero_flag    (zero_flag),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .count_enable (count_enable),
    .load_address (load_address),
    .jump_enable  (jump_enable),
    .jump_address (jump_address),
    .exec_valid   (exec_valid),
    .alu_op       (alu_op),
    .ir           (ir),
    .busy         (busy),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctrl = {imem_req, dmem_req, dmem_we, count_enable, load_address,
                 jump_enable, exec_valid, busy, halted};

  // Behavioural program counter obeying the PC contract, with its own reset.
  always @(posedge clk) begin
    if (reset) tb_pc <= 16'h0000;
    else if (load_address && count_enable) tb_pc <= tb_pc + 16'h0001;
    else if (load_address && jump_enable) tb_pc <= jump_address;
  end

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // act = sequencer is working (busy and PC enabled).
  function automatic logic [8:0] exp_vec(input logic imem, input logic dmem, input logic we,
                                         input logic ce, input logic je, input logic ev,
                                         input logic act, input logic hlt);
    return {imem, dmem, we, ce, act, je, ev, act, hlt};
  endfunction

  task automatic chk_ctrl(input string tag, input logic [8:0] exp);
    n_tests++;
    assert (ctrl === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, ctrl, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic st, input logic ia, input logic [15:0] id,
                      input logic da, input logic zf);
    @(negedge clk);
    reset     = rst;
    start     = st;
    imem_ack  = ia;
    imem_data = id;
    dmem_ack  = da;
    zero_flag = zf;
    #1;
  endtask

  // Reset with start asserted on the same edge; start must be ignored.
  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1, rbit());
    tick(1'b1, rbit(), rbit(), 16'($urandom), rbit(), rbit());
    tick(1'b0, 1'b0, rbit(), 16'($urandom), rbit(), rbit());
    exp_pc = 16'h0000;
    cur_ir = 16'h0000;
    chk_ctrl("reset_ctrl", 9'b0);
    chk16("reset_ir", ir, 16'h0000);
    chk16("reset_jaddr", jump_address, 16'h0000);
    chk16("reset_aluop", {12'h000, alu_op}, 16'h0000);
    chk16("reset_daddr", {4'h0, dmem_addr}, 16'h0000);
    tick(1'b0, 1'b0, rbit(), 16'($urandom), rbit(), rbit());
    chk_ctrl("idle_hold", 9'b0);
  endtask

  task automatic do_start();
    tick(1'b0, 1'b1, rbit(), 16'($urandom), rbit(), rbit());
    chk_ctrl("idle_start", 9'b0);
  endtask

  task automatic run_instr(input logic [15:0] instr, input int fd, input int md, input logic zf);
    logic [3:0] op;
    logic       jump;
    op = instr[15:12];
    for (int i = 0; i <= fd; i++) begin
      tick(1'b0, rbit(), (i == fd), (i == fd) ? instr : 16'($urandom), rbit(), rbit());
      chk_ctrl("fetch", exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      if (i == 0) chk16("pc", tb_pc, exp_pc);
      if (i < fd) chk16("ir_hold", ir, cur_ir);
    end
    tick(1'b0, rbit(), rbit(), 16'($urandom), rbit(), rbit());
    chk_ctrl("decode", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    chk16("ir_load", ir, instr);
    cur_ir = instr;
    if (op == 4'hF) begin
      tick(1'b0, rbit(), rbit(), 16'($urandom), rbit(), rbit());
      chk_ctrl("halt", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      chk16("halt_pc", tb_pc, exp_pc);
    end else if (op == 4'h2 || op == 4'h3) begin
      for (int j = 0; j <= md; j++) begin
        tick(1'b0, rbit(), rbit(), 16'($urandom), (j == md), rbit());
        chk_ctrl("mem", exp_vec(1'b0, 1'b1, (op == 4'h3), (j == md), 1'b0,
                                (j == md) && (op == 4'h2), 1'b1, 1'b0));
        chk16("daddr", {4'h0, dmem_addr}, {4'h0, instr[11:0]});
      end
      exp_pc = exp_pc + 16'h0001;
    end else begin
      jump = (op == 4'h8) || (op == 4'h9 && zf);
      tick(1'b0, rbit(), rbit(), 16'($urandom), rbit(), zf);
      chk_ctrl("exec", exp_vec(1'b0, 1'b0, 1'b0, !jump, jump, (op == 4'h1), 1'b1, 1'b0));
      chk16("aluop", {12'h000, alu_op}, {12'h000, instr[11:8]});
      if (jump) begin
        chk16("jaddr", jump_address, {4'h0, instr[11:0]});
        exp_pc = {4'h0, instr[11:0]};
      end else begin
        exp_pc = exp_pc + 16'h0001;
      end
    end
  endtask

  initial begin
    logic [15:0] instr;
    reset     = 1'b1;
    start     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    dmem_ack  = 1'b0;
    zero_flag = 1'b0;

    // NOP, NOP, HALT with zero-wait memory; halted from cycle 9.
    do_reset();
    do_start();
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'hF000, 0, 0, 1'b0);
    chk16("pc_after_nops", tb_pc, 16'h0002);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, rbit(), rbit(), 16'($urandom), rbit(), rbit());
      chk_ctrl("halt_sticky", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    chk16("halt_ir", ir, 16'hF000);

    // Directed opcodes, then a random instruction stream.
    do_reset();
    do_start();
    run_instr(16'h1A05, 0, 0, 1'b0);
    run_instr(16'h8A98, 0, 0, 1'b0);
    run_instr(16'h9123, 0, 0, 1'b0);
    run_instr(16'h9123, 1, 0, 1'b1);
    run_instr(16'h3055, 0, 3, 1'b0);
    run_instr(16'h2ABC, 2, 1, 1'b0);
    run_instr(16'h5FFF, 0, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      instr = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(instr, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    end
    run_instr(16'hF123, 2, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, rbit(), rbit(), 16'($urandom), rbit(), rbit());
      chk_ctrl("halt_sticky2", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end

    // Withheld imem_ack, then reset during FETCH abandons the fetch.
    do_reset();
    do_start();
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, rbit(), 1'b0, 16'($urandom), rbit(), rbit());
      chk_ctrl("fetch_wait", exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    tick(1'b1, 1'b0, 1'b1, 16'h1234, rbit(), rbit());
    chk_ctrl("fetch_at_reset", exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(1'b0, 1'b0, 1'b1, 16'($urandom), rbit(), rbit());
    chk_ctrl("after_reset", 9'b0);
    chk16("after_reset_ir", ir, 16'h0000);
    chk16("after_reset_pc", tb_pc, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
